// File: rtl/branch_predictor_btb_if.sv
// rtl/branch_predictor_btb_if.sv - lookup/update/redirect signal bundle for the BTB predictor
interface branch_predictor_btb_if #(
  parameter int ADDR_W = 12
);
  logic [ADDR_W-1:0] LK_PC;
  logic              LK_HIT;
  logic              LK_TAKEN;
  logic [ADDR_W-1:0] LK_NEXT_PC;
  logic              UPD_VALID;
  logic [ADDR_W-1:0] UPD_PC;
  logic              UPD_TAKEN;
  logic [ADDR_W-1:0] UPD_TARGET;
  logic              UPD_PRED_TAKEN;
  logic [ADDR_W-1:0] UPD_PRED_PC;
  logic              FLUSH;
  logic [ADDR_W-1:0] REDIRECT_PC;
  logic [31:0]       NUM_UPD;
  logic [31:0]       NUM_MISPRED;

  modport master (
    output LK_PC, UPD_VALID, UPD_PC, UPD_TAKEN, UPD_TARGET, UPD_PRED_TAKEN, UPD_PRED_PC,
    input  LK_HIT, LK_TAKEN, LK_NEXT_PC, FLUSH, REDIRECT_PC, NUM_UPD, NUM_MISPRED
  );

  modport slave (
    input  LK_PC, UPD_VALID, UPD_PC, UPD_TAKEN, UPD_TARGET, UPD_PRED_TAKEN, UPD_PRED_PC,
    output LK_HIT, LK_TAKEN, LK_NEXT_PC, FLUSH, REDIRECT_PC, NUM_UPD, NUM_MISPRED
  );
endinterface

// File: rtl/branch_predictor_btb.sv
// rtl/branch_predictor_btb.sv - direct-mapped BTB with saturating counters and mispredict redirect
module branch_predictor_btb #(
  parameter int ADDR_W  = 12,
  parameter int ENTRIES = 16,
  parameter int CTR_W   = 2
) (
  input logic              CLK,
  input logic              RSTn,
  branch_predictor_btb_if.slave bp
);
  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = ADDR_W - IDX_W - 2;
  localparam logic [CTR_W-1:0] CTR_WT  = CTR_W'(1) << (CTR_W - 1);
  localparam logic [CTR_W-1:0] CTR_WNT = CTR_WT - CTR_W'(1);
  localparam logic [CTR_W-1:0] CTR_MAX = '1;

  logic              validQ  [ENTRIES];
  logic [TAG_W-1:0]  tagQ    [ENTRIES];
  logic [ADDR_W-1:0] targetQ [ENTRIES];
  logic [CTR_W-1:0]  ctrQ    [ENTRIES];
  logic [31:0]       numUpdQ;
  logic [31:0]       numMispredQ;

  logic [IDX_W-1:0]  lkIdx;
  logic [TAG_W-1:0]  lkTag;
  logic              lkHit;
  logic              lkTaken;
  logic [IDX_W-1:0]  updIdx;
  logic [TAG_W-1:0]  updTag;
  logic              updHit;
  logic [ADDR_W-1:0] correctPc;
  logic              flush;

  assign lkIdx   = bp.LK_PC[IDX_W+1:2];
  assign lkTag   = bp.LK_PC[ADDR_W-1:IDX_W+2];
  assign lkHit   = validQ[lkIdx] && (tagQ[lkIdx] == lkTag);
  assign lkTaken = lkHit && ctrQ[lkIdx][CTR_W-1];

  assign bp.LK_HIT     = lkHit;
  assign bp.LK_TAKEN   = lkTaken;
  assign bp.LK_NEXT_PC = lkTaken ? targetQ[lkIdx] : bp.LK_PC + ADDR_W'(4);

  assign updIdx = bp.UPD_PC[IDX_W+1:2];
  assign updTag = bp.UPD_PC[ADDR_W-1:IDX_W+2];
  assign updHit = validQ[updIdx] && (tagQ[updIdx] == updTag);

  // Mispredict check stays live during reset so the pipeline can still squash.
  assign correctPc = bp.UPD_TAKEN ? bp.UPD_TARGET : bp.UPD_PC + ADDR_W'(4);
  assign flush     = bp.UPD_VALID &&
                     ((bp.UPD_PRED_TAKEN != bp.UPD_TAKEN) || (bp.UPD_PRED_PC != correctPc));

  assign bp.FLUSH       = flush;
  assign bp.REDIRECT_PC = correctPc;
  assign bp.NUM_UPD     = numUpdQ;
  assign bp.NUM_MISPRED = numMispredQ;

  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      for (int i = 0; i < ENTRIES; i++) begin
        validQ[i] <= 1'b0;
        ctrQ[i]   <= CTR_WNT;
      end
      numUpdQ     <= '0;
      numMispredQ <= '0;
    end else if (bp.UPD_VALID) begin
      numUpdQ <= numUpdQ + 32'd1;
      if (flush) begin
        numMispredQ <= numMispredQ + 32'd1;
      end
      if (updHit) begin
        if (bp.UPD_TAKEN) begin
          targetQ[updIdx] <= bp.UPD_TARGET;
          if (ctrQ[updIdx] != CTR_MAX) begin
            ctrQ[updIdx] <= ctrQ[updIdx] + CTR_W'(1);
          end
        end else if (ctrQ[updIdx] != '0) begin
          ctrQ[updIdx] <= ctrQ[updIdx] - CTR_W'(1);
        end
      end else if (bp.UPD_TAKEN) begin
        // Untaken misses never allocate: they would only predict fall-through anyway.
        validQ[updIdx]  <= 1'b1;
        tagQ[updIdx]    <= updTag;
        targetQ[updIdx] <= bp.UPD_TARGET;
        ctrQ[updIdx]    <= CTR_WT;
      end
    end
  end
endmodule

// File: tb/tb_branch_predictor_btb.sv
// tb/tb_branch_predictor_btb.sv - directed and randomized checks of branch_predictor_btb against a table model
module tb_branch_predictor_btb;
  localparam int AW   = 12;
  localparam int NE   = 16;
  localparam int AMOD = 4096;

  logic CLK = 1'b0;
  logic RSTn;
  int   nCmp  = 0;
  int   nFail = 0;

  branch_predictor_btb_if #(.ADDR_W(AW)) bp ();

  branch_predictor_btb #(.ADDR_W(AW), .ENTRIES(NE), .CTR_W(2)) dut (
    .CLK (CLK),
    .RSTn(RSTn),
    .bp  (bp)
  );

  always #5 CLK = ~CLK;

  bit          mValid [NE];
  int          mTag   [NE];
  int          mTgt   [NE];
  int          mCtr   [NE];
  logic [31:0] mNumUpd;
  logic [31:0] mNumMis;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nCmp++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic mReset();
    for (int i = 0; i < NE; i++) begin
      mValid[i] = 1'b0;
      mCtr[i]   = 1;
    end
    mNumUpd = 0;
    mNumMis = 0;
  endtask

  task automatic mLook(input int pc, output bit hit, output bit tk, output int nxt);
    int idx;
    idx = (pc / 4) % NE;
    hit = mValid[idx] && (mTag[idx] == pc / (4 * NE));
    tk  = hit && (mCtr[idx] >= 2);
    nxt = tk ? mTgt[idx] : (pc + 4) % AMOD;
  endtask

  // One clock: drive at negedge, check combinational and registered outputs, then advance the model.
  task automatic cyc(input int lk, input bit uv, input int up, input bit tk, input int tg,
                     input bit ptk, input int ppc, input bit rst);
    bit eh, et, ef, uhit;
    int en, corr, idx;
    @(negedge CLK);
    RSTn              = !rst;
    bp.LK_PC          = AW'(lk);
    bp.UPD_VALID      = uv;
    bp.UPD_PC         = AW'(up);
    bp.UPD_TAKEN      = tk;
    bp.UPD_TARGET     = AW'(tg);
    bp.UPD_PRED_TAKEN = ptk;
    bp.UPD_PRED_PC    = AW'(ppc);
    #1;
    mLook(lk, eh, et, en);
    corr = tk ? tg : (up + 4) % AMOD;
    ef   = uv && ((ptk != tk) || (ppc != corr));
    chk("lk_hit", 32'(bp.LK_HIT), 32'(eh));
    chk("lk_taken", 32'(bp.LK_TAKEN), 32'(et));
    chk("lk_next_pc", 32'(bp.LK_NEXT_PC), 32'(en));
    chk("flush", 32'(bp.FLUSH), 32'(ef));
    if (uv) chk("redirect_pc", 32'(bp.REDIRECT_PC), 32'(corr));
    chk("num_upd", bp.NUM_UPD, mNumUpd);
    chk("num_mispred", bp.NUM_MISPRED, mNumMis);
    if (rst) begin
      mReset();
    end else if (uv) begin
      mNumUpd++;
      if (ef) mNumMis++;
      idx  = (up / 4) % NE;
      uhit = mValid[idx] && (mTag[idx] == up / (4 * NE));
      if (uhit) begin
        if (tk) begin
          mTgt[idx] = tg;
          mCtr[idx] = (mCtr[idx] < 3) ? mCtr[idx] + 1 : 3;
        end else begin
          mCtr[idx] = (mCtr[idx] > 0) ? mCtr[idx] - 1 : 0;
        end
      end else if (tk) begin
        mValid[idx] = 1'b1;
        mTag[idx]   = up / (4 * NE);
        mTgt[idx]   = tg;
        mCtr[idx]   = 2;
      end
    end
  endtask

  task automatic look(input int lk);
    cyc(lk, 1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b0);
  endtask

  function automatic int randPc();
    if ($urandom_range(0, 7) == 0) return 'hFC0 + 4 * $urandom_range(0, 15) + $urandom_range(0, 3);
    return 4 * $urandom_range(0, 63) + (($urandom_range(0, 3) == 0) ? $urandom_range(0, 3) : 0);
  endfunction

  initial begin
    RSTn              = 1'b0;
    bp.LK_PC          = '0;
    bp.UPD_VALID      = 1'b0;
    bp.UPD_PC         = '0;
    bp.UPD_TAKEN      = 1'b0;
    bp.UPD_TARGET     = '0;
    bp.UPD_PRED_TAKEN = 1'b0;
    bp.UPD_PRED_PC    = '0;
    repeat (2) @(posedge CLK);
    mReset();

    look('h010);
    chk("r38_hit", 32'(bp.LK_HIT), 32'd0);
    chk("r38_next", 32'(bp.LK_NEXT_PC), 32'h014);
    chk("r38_num_upd", bp.NUM_UPD, 32'd0);

    cyc('h010, 1, 'h010, 1, 'h080, 0, 'h014, 0);
    chk("r39_flush", 32'(bp.FLUSH), 32'd1);
    chk("r39_redirect", 32'(bp.REDIRECT_PC), 32'h080);
    look('h010);
    chk("r39_hit", 32'(bp.LK_HIT), 32'd1);
    chk("r39_taken", 32'(bp.LK_TAKEN), 32'd1);
    chk("r39_next", 32'(bp.LK_NEXT_PC), 32'h080);
    chk("r39_mispred", bp.NUM_MISPRED, 32'd1);

    cyc('h010, 1, 'h010, 0, 'h000, 1, 'h080, 0);
    cyc('h010, 1, 'h010, 0, 'h000, 0, 'h014, 0);
    chk("r40_taken_after_first", 32'(bp.LK_TAKEN), 32'd0);
    chk("r40_nomispred", 32'(bp.FLUSH), 32'd0);
    cyc('h010, 1, 'h010, 0, 'h000, 0, 'h014, 0);
    cyc('h010, 1, 'h010, 1, 'h080, 0, 'h014, 0);
    look('h010);
    chk("r40_saturated_low", 32'(bp.LK_TAKEN), 32'd0);
    chk("r40_next", 32'(bp.LK_NEXT_PC), 32'h014);

    cyc('h050, 1, 'h050, 1, 'h0A0, 0, 'h054, 0);
    look('h010);
    chk("r41_old_miss", 32'(bp.LK_HIT), 32'd0);
    look('h050);
    chk("r41_new_hit", 32'(bp.LK_HIT), 32'd1);
    chk("r41_new_next", 32'(bp.LK_NEXT_PC), 32'h0A0);

    cyc('h020, 1, 'h020, 1, 'h100, 0, 'h024, 0);
    chk("r42_same_cycle", 32'(bp.LK_HIT), 32'd0);
    look('h020);
    chk("r42_next_cycle", 32'(bp.LK_HIT), 32'd1);

    cyc('h030, 1, 'h030, 1, 'h200, 0, 'h034, 1);
    chk("r43_flush_in_reset", 32'(bp.FLUSH), 32'd1);
    look('h030);
    chk("r43_empty", 32'(bp.LK_HIT), 32'd0);
    chk("r43_num_upd", bp.NUM_UPD, 32'd0);
    look('h050);
    chk("r43_cleared", 32'(bp.LK_HIT), 32'd0);

    for (int n = 0; n < 600; n++) begin
      int  up, lk, tg, ppc;
      bit  uv, tk, ptk, ph, rst;
      lk  = ($urandom_range(0, 1) == 0) ? randPc() : 0;
      up  = randPc();
      if (lk == 0) lk = up;
      uv  = ($urandom_range(0, 3) != 0);
      tk  = $urandom_range(0, 1);
      tg  = $urandom_range(0, AMOD - 1);
      rst = ($urandom_range(0, 63) == 0);
      if ($urandom_range(0, 1) == 0) begin
        mLook(up, ph, ptk, ppc);
      end else begin
        ptk = $urandom_range(0, 1);
        ppc = ($urandom_range(0, 1) == 0) ? tg : $urandom_range(0, AMOD - 1);
      end
      cyc(lk, uv, up, tk, tg, ptk, ppc, rst);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
    $finish;
  end
endmodule
